// File: rtl/vga_timing_gen.sv
`default_nettype none
//==============================================================================
// Module : vga_timing_gen
// Desc   : Parametrised VGA timing generator with pixel clock-enable, delayed
//          sync/video/coordinate outputs, line/frame strobes and frame counter.
// Rev    : 1.0 - initial release
//==============================================================================
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE     = 0,
  parameter int CW       = 10
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  input  logic          en,
  output logic          pix_ce,
  output logic          h_sync,
  output logic          v_sync,
  output logic          video_on,
  output logic [CW-1:0] x_loc,
  output logic [CW-1:0] y_loc,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_HS_BEG  = H_ACTIVE + H_FP;
  localparam int c_HS_END  = c_HS_BEG + H_SYNC;
  localparam int c_VS_BEG  = V_ACTIVE + V_FP;
  localparam int c_VS_END  = c_VS_BEG + V_SYNC;
  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_FILL_W  = (PIPE > 0) ? $clog2(PIPE + 1) : 1;
  localparam int c_VEC_W   = 3 + 2 * CW;

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PIPE);
  localparam logic [CW-1:0]       c_H_LAST    = CW'(c_H_TOTAL - 1);
  localparam logic [CW-1:0]       c_V_LAST    = CW'(c_V_TOTAL - 1);
  localparam logic                c_HS_ON     = (HS_POL != 0);
  localparam logic                c_VS_ON     = (VS_POL != 0);
  // Vector layout: {h_sync, v_sync, video_on, x, y}
  localparam logic [c_VEC_W-1:0]  c_BLANK     = {~c_HS_ON, ~c_VS_ON, 1'b0, {CW{1'b0}}, {CW{1'b0}}};

  logic [c_DIV_W-1:0]  r_div_cnt;
  logic                r_pix_ce;
  logic                w_tick;
  logic [CW-1:0]       r_h;
  logic [CW-1:0]       r_v;
  logic                w_hs_act;
  logic                w_vs_act;
  logic                w_video;
  logic [c_VEC_W-1:0]  w_dec;
  logic [c_VEC_W-1:0]  r_pipe     [PIPE+1];
  logic [c_VEC_W-1:0]  w_shift_in [PIPE+1];
  logic [c_VEC_W-1:0]  w_last_in;
  logic [c_VEC_W-1:0]  w_out;
  logic [c_FILL_W-1:0] r_fill;
  logic                w_load_line;
  logic                w_load_frame;
  logic                r_line_start;
  logic                r_frame_start;
  logic [15:0]         r_frame_cnt;

  // pix_ce is held (not cleared) while en is low so a pending tick survives a pause
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_pix_ce  <= 1'b0;
    end else if (en) begin
      r_pix_ce  <= (r_div_cnt == c_DIV_LAST);
      r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  assign w_tick = r_pix_ce & en;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (r_h == c_H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign w_hs_act = (int'(r_h) >= c_HS_BEG) && (int'(r_h) < c_HS_END);
  assign w_vs_act = (int'(r_v) >= c_VS_BEG) && (int'(r_v) < c_VS_END);
  assign w_video  = (int'(r_h) < H_ACTIVE) && (int'(r_v) < V_ACTIVE);
  assign w_dec    = {w_hs_act ? c_HS_ON : ~c_HS_ON,
                     w_vs_act ? c_VS_ON : ~c_VS_ON,
                     w_video, r_h, r_v};

  always_comb begin
    w_shift_in[0] = w_dec;
    for (int i = 1; i <= PIPE; i++) begin
      w_shift_in[i] = r_pipe[i-1];
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= PIPE; i++) begin
        r_pipe[i] <= c_BLANK;
      end
    end else if (w_tick) begin
      for (int i = 0; i <= PIPE; i++) begin
        r_pipe[i] <= w_shift_in[i];
      end
    end
  end

  // Counts ticks until real data reaches the stage feeding the output register
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_fill <= '0;
    end else if (w_tick && (r_fill != c_FILL_FULL)) begin
      r_fill <= r_fill + 1'b1;
    end
  end

  assign w_last_in    = w_shift_in[PIPE];
  assign w_load_line  = w_tick && (r_fill == c_FILL_FULL) && (w_last_in[2*CW-1:CW] == '0);
  assign w_load_frame = w_load_line && (w_last_in[CW-1:0] == '0);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else if (en) begin
      r_line_start  <= w_load_line;
      r_frame_start <= w_load_frame;
      if (w_load_frame) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign w_out       = r_pipe[PIPE];
  assign pix_ce      = r_pix_ce & en;
  assign h_sync      = w_out[c_VEC_W-1];
  assign v_sync      = w_out[c_VEC_W-2];
  assign video_on    = w_out[c_VEC_W-3];
  assign x_loc       = w_out[2*CW-1:CW];
  assign y_loc       = w_out[CW-1:0];
  assign line_start  = r_line_start & en;
  assign frame_start = r_frame_start & en;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator. It replaces the fixed clock divider, h/v counters and sync decode in the display path with one block. It derives a pixel clock-enable from CLK100MHZ and produces polarity-configurable h_sync/v_sync, video_on, pixel coordinates, line/frame strobes and a frame counter. All outputs are delayed by a programmable number of pixel ticks so they align with a pipelined pixel generator.

## Interface
- CLK_DIV, 4: CLK100MHZ cycles per pixel tick (≥1)
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal segment lengths in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical segment lengths in lines
- HS_POL, 0 / VS_POL, 0: sync active level (0 = active-low)
- PIPE, 0: extra output delay in pixel ticks (0..7)
- CW, 10: coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CW
- CLK100MHZ  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  run enable; low freezes the block
- pix_ce  out  1  pixel tick, one CLK100MHZ cycle wide
- h_sync  out  1  horizontal sync at HS_POL
- v_sync  out  1  vertical sync at VS_POL
- video_on  out  1  high inside active area
- x_loc  out  CW  horizontal count (raw, 0..H_TOTAL-1)
- y_loc  out  CW  vertical count (raw, 0..V_TOTAL-1)
- line_start  out  1  one-cycle strobe, outputs show x_loc=0
- frame_start  out  1  one-cycle strobe, outputs show x_loc=0, y_loc=0
- frame_cnt  out  16  frames started since reset, wraps

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider div_cnt counts 0..CLK_DIV-1 while en=1. pix_ce is registered, high in the cycle after div_cnt = CLK_DIV-1. CLK_DIV=1 gives pix_ce constantly high while en=1.
- A "tick" is a rising edge with pix_ce=1. On each tick, h advances; h = H_TOTAL-1 wraps to 0 and advances v. v = V_TOTAL-1 wraps to 0.
- Decode from (h,v):
  - video_on = (h<H_ACTIVE) && (v<V_ACTIVE)
  - hs_act = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vs_act = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC
  - h_sync = hs_act ? HS_POL : !HS_POL; v_sync likewise
- The decoded vector {h_sync, v_sync, video_on, x, y} enters a shift pipeline of PIPE+1 registers, all loading on ticks. Outputs come from the last stage.
- line_start/frame_start are high for the single CLK100MHZ cycle after the tick that loads x=0 (resp. x=0,y=0) into the output stage. frame_cnt increments in that same cycle and wraps 0xFFFF→0.
- en=0: div_cnt, counters, pipeline and frame_cnt hold. pix_ce=0 and strobes=0. Resume continues from the held state with no lost or duplicated ticks.
- Reset (any time, mid-frame included) values:
  - div_cnt=0, h=0, v=0
  - all pipeline stages blank: video_on=0, x_loc=0, y_loc=0, h_sync=!HS_POL, v_sync=!VS_POL
  - pix_ce=0, line_start=0, frame_start=0, frame_cnt=0

## Timing
- First pix_ce after reset release with en=1: cycle CLK_DIV, counting the first post-reset edge as cycle 1.
- Latency: counter state (h,v) appears at outputs PIPE+1 ticks later. Outputs are stable for CLK_DIV cycles between ticks.
- After reset, outputs first show (0,0) after tick PIPE+1. The first frame_start asserts in the cycle following that tick.
- Sync, video_on and coordinates change only on tick edges and are mutually aligned; no glitches, since all outputs are registered.
- Line period = H_TOTAL·CLK_DIV cycles; frame period = H_TOTAL·V_TOTAL·CLK_DIV cycles.

## Test plan
- Defaults, en=1, run 2 frames:
  - h_sync period 3200 cycles, low 384 cycles, falling edge when x_loc=656
  - v_sync low for 2 lines starting y_loc=490
  - video_on high 307200 ticks per frame
  - frame_start period 1,680,000 cycles
- Small config H=8/1/2/1, V=4/1/1/1, CLK_DIV=1, HS_POL=VS_POL=1, PIPE=2:
  - pix_ce always high
  - (0,0) first on outputs at tick 3
  - h_sync high exactly at x=9,10
  - v_sync high at y=5
  - frame period 84 cycles
- Same config with PIPE=0 vs PIPE=5, run in parallel: output vectors identical, shifted by exactly 5 ticks.
- en dropped for 37 cycles at x=300 (defaults): all outputs and div_cnt frozen; after resume, the sequence continues 300→301 with the correct sub-tick phase.
- Reset asserted mid-frame (y=200) for 3 cycles, with no clock edge required during it:
  - outputs go to reset values immediately
  - frame_cnt=0
  - restart timing identical to power-on
- Wrap: force 65536 frames on the small config; frame_cnt returns to 0 with frame_start asserted.
